cache_mshr_chain: RTL and testbench

- Next-generation per-bank miss status holding register for the writeback cache bank.
- Tracks outstanding misses as per-line linked chains and keeps the chain tail internally, so the bank no longer computes or returns a tail.
- Adds single-cycle allocate-with-link, a primary/secondary miss indication, occupancy and almost-full status, and a flush drain.
- Sits between bank pipeline stage 0 (allocate/release), the memory response path (fill) and the replay arbiter (dequeue).

---
 rtl/cache_mshr_pkg.sv | 28 ++
 rtl/cache_mshr_freelist.sv | 40 ++++
 rtl/cache_mshr_chain.sv | 233 +++++++++++++++++++++++
 tb/tb_cache_mshr_chain.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mshr_pkg.sv
// Shared defaults, types and replay state codes for the chained per-bank MSHR.
package cache_mshr_pkg;

  localparam int unsigned LINE_ADDR_W_DEF  = 26;
  localparam int unsigned DATA_W_DEF       = 64;
  localparam int unsigned MSHR_SIZE_DEF    = 8;
  localparam int unsigned ID_W_DEF         = $clog2(MSHR_SIZE_DEF);
  localparam int unsigned AFULL_THRESH_DEF = MSHR_SIZE_DEF - 2;

  typedef logic [ID_W_DEF-1:0] mshr_id_t;

  typedef struct packed {
    logic [LINE_ADDR_W_DEF-1:0] addr;
    logic                       rw;
    logic                       filled;
    logic                       has_next;
    mshr_id_t                   next_idx;
    logic                       tail;
  } mshr_entry_t;

  localparam logic [0:0] RP_IDLE   = 1'b0;
  localparam logic [0:0] RP_ACTIVE = 1'b1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_mshr_freelist.sv
// Lowest-index free slot select; id and availability are registered.
module cache_mshr_freelist #(
  parameter int unsigned MSHR_SIZE = 8,
  parameter int unsigned ID_W      = $clog2(MSHR_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [MSHR_SIZE-1:0] busy_next,
  output logic [ID_W-1:0]      alloc_id,
  output logic                 free_avail
);

  logic [ID_W-1:0] id_d, id_q;
  logic            avail_d, avail_q;

  always_comb begin
    id_d    = '0;
    avail_d = 1'b0;
    for (int unsigned i = MSHR_SIZE; i > 0; i--) begin
      if (!busy_next[i-1]) begin
        id_d    = ID_W'(i - 1);
        avail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      id_q    <= '0;
      avail_q <= 1'b1;
    end else begin
      id_q    <= id_d;
      avail_q <= avail_d;
    end
  end

  assign alloc_id   = id_q;
  assign free_avail = avail_q;

endmodule

// File: rtl/cache_mshr_chain.sv
// Per-bank MSHR tracking misses as per-line linked chains with replay walk.
// Optional perf counters are enabled with the MSHR_PERF_EN macro.
module cache_mshr_chain
  import cache_mshr_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W  = LINE_ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MSHR_SIZE    = MSHR_SIZE_DEF,
  parameter int unsigned ID_W         = $clog2(MSHR_SIZE),
  parameter int unsigned AFULL_THRESH = MSHR_SIZE - 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [LINE_ADDR_W-1:0] alloc_addr,
  input  logic                   alloc_rw,
  input  logic [DATA_W-1:0]      alloc_data,
  output logic [ID_W-1:0]        alloc_id,
  output logic                   alloc_primary,
  input  logic                   release_valid,
  input  logic [ID_W-1:0]        release_id,
  input  logic                   fill_valid,
  input  logic [ID_W-1:0]        fill_id,
  output logic [LINE_ADDR_W-1:0] fill_addr,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [ID_W-1:0]        deq_id,
  output logic [LINE_ADDR_W-1:0] deq_addr,
  output logic                   deq_rw,
  output logic [DATA_W-1:0]      deq_data,
  output logic                   deq_last,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic [ID_W:0]          occupancy,
  output logic                   almost_full
`ifdef MSHR_PERF_EN
  ,
  output logic [31:0]            perf_allocs,
  output logic [31:0]            perf_secondary,
  output logic [31:0]            perf_full_stalls
`endif
);

  localparam logic [ID_W:0] AFULL_L = (ID_W+1)'(AFULL_THRESH);
  localparam logic [ID_W:0] FULL_L  = (ID_W+1)'(MSHR_SIZE);

  logic [MSHR_SIZE-1:0]   valid_d, valid_q, filled_d, filled_q;
  logic [MSHR_SIZE-1:0]   has_next_d, has_next_q, tail_d, tail_q;
  logic [ID_W-1:0]        next_d [MSHR_SIZE];
  logic [ID_W-1:0]        next_q [MSHR_SIZE];
  logic [LINE_ADDR_W-1:0] addr_d [MSHR_SIZE];
  logic [LINE_ADDR_W-1:0] addr_q [MSHR_SIZE];
  logic [DATA_W:0]        pay_mem [MSHR_SIZE];

  logic [0:0]      rp_state_d, rp_state_q;
  logic [ID_W-1:0] ptr_d, ptr_q;
  logic [ID_W:0]   occ_d, occ_q;
  logic            flush_done_d, flush_done_q;

  logic                 free_avail, alloc_fire, deq_fire, match_any, fill_same_line;
  logic [ID_W-1:0]      match_idx;
  logic [MSHR_SIZE-1:0] busy_next;

  assign alloc_ready    = free_avail && !flush_req;
  assign alloc_fire     = alloc_valid && alloc_ready;
  assign deq_fire       = (rp_state_q == RP_ACTIVE) && deq_ready;
  assign fill_addr      = addr_q[fill_id];
  assign fill_same_line = fill_valid && (alloc_addr == fill_addr);

  // Slots freed this cycle stay busy for one selection round.
  always_comb begin
    busy_next = valid_q;
    if (alloc_fire) busy_next[alloc_id] = 1'b1;
  end

  cache_mshr_freelist #(
    .MSHR_SIZE (MSHR_SIZE),
    .ID_W      (ID_W)
  ) u_freelist (
    .clk        (clk),
    .reset_n    (reset_n),
    .busy_next  (busy_next),
    .alloc_id   (alloc_id),
    .free_avail (free_avail)
  );

  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < MSHR_SIZE; i++) begin
      if (valid_q[i] && !filled_q[i] && tail_q[i] && (addr_q[i] == alloc_addr) && !fill_same_line) begin
        match_any = 1'b1;
        match_idx = ID_W'(i);
      end
    end
  end

  assign alloc_primary = !match_any;

  always_comb begin
    valid_d    = valid_q;
    filled_d   = filled_q;
    has_next_d = has_next_q;
    tail_d     = tail_q;
    next_d     = next_q;
    addr_d     = addr_q;
    rp_state_d = rp_state_q;
    ptr_d      = ptr_q;

    if (release_valid) valid_d[release_id] = 1'b0;

    if (deq_fire) begin
      valid_d[ptr_q] = 1'b0;
      if (has_next_q[ptr_q]) begin
        ptr_d                   = next_q[ptr_q];
        filled_d[next_q[ptr_q]] = 1'b1;
      end else begin
        rp_state_d = RP_IDLE;
      end
    end

    // Marking the chain tail at fill time keeps later same-line misses off the replaying chain.
    if (fill_valid) begin
      rp_state_d        = RP_ACTIVE;
      ptr_d             = fill_id;
      filled_d[fill_id] = 1'b1;
      for (int unsigned i = 0; i < MSHR_SIZE; i++) begin
        if (valid_q[i] && !filled_q[i] && tail_q[i] && (addr_q[i] == fill_addr)) filled_d[i] = 1'b1;
      end
    end

    if (alloc_fire) begin
      valid_d[alloc_id]    = 1'b1;
      filled_d[alloc_id]   = 1'b0;
      tail_d[alloc_id]     = 1'b1;
      has_next_d[alloc_id] = 1'b0;
      next_d[alloc_id]     = '0;
      addr_d[alloc_id]     = alloc_addr;
      if (match_any) begin
        has_next_d[match_idx] = 1'b1;
        next_d[match_idx]     = alloc_id;
        tail_d[match_idx]     = 1'b0;
      end
    end

    occ_d = occ_q + (ID_W+1)'(alloc_fire) - (ID_W+1)'(release_valid) - (ID_W+1)'(deq_fire);
    flush_done_d = flush_req && (occ_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q      <= '0;
      filled_q     <= '0;
      has_next_q   <= '0;
      tail_q       <= '0;
      rp_state_q   <= RP_IDLE;
      ptr_q        <= '0;
      occ_q        <= '0;
      flush_done_q <= 1'b0;
      for (int unsigned i = 0; i < MSHR_SIZE; i++) begin
        next_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      filled_q     <= filled_d;
      has_next_q   <= has_next_d;
      tail_q       <= tail_d;
      next_q       <= next_d;
      addr_q       <= addr_d;
      rp_state_q   <= rp_state_d;
      ptr_q        <= ptr_d;
      occ_q        <= occ_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) pay_mem[alloc_id] <= {alloc_rw, alloc_data};
  end

  assign deq_valid   = (rp_state_q == RP_ACTIVE);
  assign deq_id      = ptr_q;
  assign deq_addr    = addr_q[ptr_q];
  assign deq_rw      = pay_mem[ptr_q][DATA_W];
  assign deq_data    = pay_mem[ptr_q][DATA_W-1:0];
  assign deq_last    = !has_next_q[ptr_q];
  assign occupancy   = occ_q;
  assign almost_full = (occ_q >= AFULL_L);
  assign flush_done  = flush_done_q;

`ifdef MSHR_PERF_EN
  logic [31:0] perf_allocs_d, perf_allocs_q, perf_sec_d, perf_sec_q, perf_stall_d, perf_stall_q;

  always_comb begin
    perf_allocs_d = perf_allocs_q;
    perf_sec_d    = perf_sec_q;
    perf_stall_d  = perf_stall_q;
    if (alloc_fire) perf_allocs_d = sat_inc32(perf_allocs_q);
    if (alloc_fire && match_any) perf_sec_d = sat_inc32(perf_sec_q);
    if (alloc_valid && !alloc_ready) perf_stall_d = sat_inc32(perf_stall_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_allocs_q <= '0;
      perf_sec_q    <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_allocs_q <= perf_allocs_d;
      perf_sec_q    <= perf_sec_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_allocs      = perf_allocs_q;
  assign perf_secondary   = perf_sec_q;
  assign perf_full_stalls = perf_stall_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (release_valid) assert (valid_q[release_id] && !has_next_q[release_id]);
      assert (!(fill_valid && (rp_state_q == RP_ACTIVE)));
      assert (!(alloc_fire && (occ_q == FULL_L)));
      assert (occ_q >= ((ID_W+1)'(release_valid) + (ID_W+1)'(deq_fire)));
    end
  end
`endif

endmodule

// File: tb/tb_cache_mshr_chain.sv
// Directed bench for cache_mshr_chain with a queue-based chain model checked every cycle.
module tb_cache_mshr_chain;

  localparam int AW = 26;
  localparam int DW = 64;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alloc_valid, alloc_ready, alloc_rw, alloc_primary;
  logic [AW-1:0] alloc_addr, fill_addr, deq_addr;
  logic [DW-1:0] alloc_data, deq_data;
  logic [IW-1:0] alloc_id, release_id, fill_id, deq_id;
  logic          release_valid, fill_valid, deq_valid, deq_ready, deq_rw, deq_last;
  logic          flush_req, flush_done, almost_full;
  logic [IW:0]   occupancy;

  always #5 clk = ~clk;

  cache_mshr_chain #(
    .LINE_ADDR_W (AW), .DATA_W (DW), .MSHR_SIZE (N), .ID_W (IW), .AFULL_THRESH (6)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .alloc_valid (alloc_valid), .alloc_ready (alloc_ready), .alloc_addr (alloc_addr),
    .alloc_rw (alloc_rw), .alloc_data (alloc_data), .alloc_id (alloc_id),
    .alloc_primary (alloc_primary),
    .release_valid (release_valid), .release_id (release_id),
    .fill_valid (fill_valid), .fill_id (fill_id), .fill_addr (fill_addr),
    .deq_valid (deq_valid), .deq_ready (deq_ready), .deq_id (deq_id), .deq_addr (deq_addr),
    .deq_rw (deq_rw), .deq_data (deq_data), .deq_last (deq_last),
    .flush_req (flush_req), .flush_done (flush_done),
    .occupancy (occupancy), .almost_full (almost_full)
  );

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: slot contents, open (unfilled) chains as queues keyed by head, replay queue.
  bit            m_valid [N];
  bit            m_freed_prev [N];
  bit            m_open [N];
  bit            m_rw [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int unsigned   chain [N][$];
  int unsigned   rq [$];
  bit            m_fd;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  // A slot freed at the last edge is not offered yet.
  function automatic int m_free_id();
    for (int i = 0; i < N; i++) if (!m_valid[i] && !m_freed_prev[i]) return i;
    return -1;
  endfunction

  function automatic int m_match_head();
    for (int h = 0; h < N; h++)
      if (m_open[h] && m_addr[h] == alloc_addr && !(fill_valid && fill_id == IW'(h))) return h;
    return -1;
  endfunction

  always @(posedge clk) begin
    int fid, head, cnt, id;
    bit rdy, freed [N];
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_freed_prev[i] = 0; m_open[i] = 0; chain[i].delete();
      end
      rq.delete();
      m_fd = 0;
    end else begin
      fid  = m_free_id();
      head = m_match_head();
      cnt  = m_count();
      rdy  = (fid >= 0) && !flush_req;
      m_fd = flush_req && (cnt == 0);
      for (int i = 0; i < N; i++) freed[i] = 0;
      if (rq.size() > 0 && deq_ready) begin
        id = rq.pop_front(); m_valid[id] = 0; freed[id] = 1;
      end
      if (release_valid) begin
        m_valid[release_id] = 0; freed[release_id] = 1; m_open[release_id] = 0;
      end
      if (fill_valid) begin
        rq = chain[fill_id]; m_open[fill_id] = 0;
      end
      if (alloc_valid && rdy) begin
        id = fid;
        if (head >= 0) chain[head].push_back(id);
        else begin
          chain[id].delete(); chain[id].push_back(id); m_open[id] = 1;
        end
        m_valid[id] = 1; m_addr[id] = alloc_addr; m_rw[id] = alloc_rw; m_data[id] = alloc_data;
      end
      for (int i = 0; i < N; i++) m_freed_prev[i] = freed[i];
    end
  end

  always @(negedge clk) begin
    int fid, cnt;
    if (checking && reset_n) begin
      fid = m_free_id();
      cnt = m_count();
      chk("alloc_ready", alloc_ready, (fid >= 0) && !flush_req);
      if (fid >= 0) chk("alloc_id", alloc_id, fid);
      if (alloc_valid && alloc_ready) chk("alloc_primary", alloc_primary, m_match_head() < 0);
      chk("deq_valid", deq_valid, rq.size() > 0);
      if (rq.size() > 0) begin
        chk("deq_id", deq_id, rq[0]);
        chk("deq_addr", deq_addr, m_addr[rq[0]]);
        chk("deq_rw", deq_rw, m_rw[rq[0]]);
        chk("deq_data", deq_data, m_data[rq[0]]);
        chk("deq_last", deq_last, rq.size() == 1);
      end
      chk("occupancy", occupancy, cnt);
      chk("almost_full", almost_full, cnt >= 6);
      chk("flush_done", flush_done, m_fd);
      if (fill_valid) chk("fill_addr", fill_addr, m_addr[fill_id]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic alloc_go(input logic [AW-1:0] a, input bit rw, input int exp_id, input bit exp_prim,
                          input string tag);
    alloc_valid = 1; alloc_addr = a; alloc_rw = rw; alloc_data = {a[31:0], 24'h0, a[7:0]} ^ 64'h5a5a;
    #1;
    chk({tag, "_id"}, alloc_id, exp_id);
    chk({tag, "_primary"}, alloc_primary, exp_prim);
    tick();
    alloc_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; alloc_valid = 0; alloc_addr = '0; alloc_rw = 0; alloc_data = '0;
    release_valid = 0; release_id = '0; fill_valid = 0; fill_id = '0; deq_ready = 0; flush_req = 0;
    tick(); tick();
    reset_n = 1;
    checking = 1;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_flush_done", flush_done, 0);

    // Single primary, then two secondaries on the same line and a 3-entry replay.
    alloc_go(26'h100, 1, 0, 1, "t1");
    chk("t1_occupancy", occupancy, 1);
    alloc_go(26'h100, 0, 1, 0, "t2a");
    alloc_go(26'h100, 1, 2, 0, "t2b");
    fill_valid = 1; fill_id = 0;
    #1 chk("t2_fill_addr", fill_addr, 26'h100);
    tick();
    fill_valid = 0; deq_ready = 1;
    #1;
    chk("t2_deq0_id", deq_id, 0); chk("t2_deq0_last", deq_last, 0);
    tick();
    chk("t2_deq1_id", deq_id, 1); chk("t2_deq1_last", deq_last, 0);
    tick();
    chk("t2_deq2_id", deq_id, 2); chk("t2_deq2_last", deq_last, 1);
    tick();
    chk("t2_deq_done", deq_valid, 0); chk("t2_occ_zero", occupancy, 0);

    // Same-line allocate during replay starts a new chain.
    tick();
    alloc_go(26'h200, 0, 0, 1, "t3a");
    alloc_go(26'h200, 1, 1, 0, "t3b");
    fill_valid = 1; fill_id = 0;
    tick();
    fill_valid = 0;
    alloc_go(26'h200, 0, 2, 1, "t3c");
    chk("t3_deq_id", deq_id, 1); chk("t3_deq_last", deq_last, 1);
    tick();
    chk("t3_deq_done", deq_valid, 0); chk("t3_occ", occupancy, 1);
    release_valid = 1; release_id = 2;
    tick();
    release_valid = 0;
    chk("t3_occ_rel", occupancy, 0);
    tick();

    // Fill all slots with distinct lines.
    for (int i = 0; i < N; i++) begin
      if (i == 5) chk("t4_afull_at5", almost_full, 0);
      if (i == 6) begin
        chk("t4_afull_at6", almost_full, 1); chk("t4_ready_at6", alloc_ready, 1);
      end
      alloc_go(26'h300 + AW'(i), i[0], i, 1, "t4");
    end
    chk("t4_full_ready", alloc_ready, 0);
    chk("t4_full_occ", occupancy, 8);
    alloc_valid = 1; alloc_addr = 26'h3ff;
    tick();
    alloc_valid = 0;
    release_valid = 1; release_id = 3;
    tick();
    release_valid = 0;
    tick();
    chk("t4_rel_ready", alloc_ready, 1);
    chk("t4_rel_id", alloc_id, 3);
    for (int i = 0; i < N; i++) begin
      if (i != 3) begin
        release_valid = 1; release_id = IW'(i);
        tick();
      end
    end
    release_valid = 0;
    tick();

    // Flush while two chains drain.
    alloc_go(26'h400, 0, 0, 1, "t5a");
    alloc_go(26'h400, 1, 1, 0, "t5b");
    alloc_go(26'h500, 0, 2, 1, "t5c");
    flush_req = 1;
    #1 chk("t5_flush_ready", alloc_ready, 0);
    fill_valid = 1; fill_id = 0;
    tick();
    fill_valid = 0;
    tick(); tick();
    fill_valid = 1; fill_id = 2;
    tick();
    fill_valid = 0;
    tick();
    chk("t5_occ_zero", occupancy, 0); chk("t5_done_lag", flush_done, 0);
    tick();
    chk("t5_flush_done", flush_done, 1);
    flush_req = 0;
    tick(); tick();

    // Reset in the middle of a replay.
    alloc_go(26'h600, 0, 0, 1, "t6a");
    alloc_go(26'h600, 1, 1, 0, "t6b");
    alloc_go(26'h600, 0, 2, 0, "t6c");
    fill_valid = 1; fill_id = 0;
    tick();
    fill_valid = 0;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    #1;
    chk("t6_deq_valid", deq_valid, 0);
    chk("t6_occ", occupancy, 0);
    alloc_go(26'h700, 0, 0, 1, "t6d");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
